// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states and snapshot decode helper for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  typedef struct packed {
    logic       single;
    logic [5:0] idx;
  } onehot_t;
  function automatic onehot_t onehot_index(input logic [63:0] v);
    onehot_t r;
    r.idx = '0;
    for (int i = 0; i < 64; i++) if (v[i]) r.idx = 6'(i);
    r.single = (v != '0) && ((v & (v - 64'd1)) == '0);
    return r;
  endfunction
endpackage

// File: rtl/key_sync.sv
// key_sync: parameterised-width 2-flop synchronizer, async active-high reset to 0
module key_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: column-strobed matrix keypad scanner with frame-level debounce and single-key event reporting
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  localparam int CW = $clog2(COLS * ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] key_row,
  output logic [COLS-1:0] key_col,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held
);
  localparam int N = COLS * ROWS;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CIW = $clog2(COLS);
  localparam int SW = $clog2(DEBOUNCE + 1);
  logic [ROWS-1:0] rows_s;
  logic [DW-1:0]   dwell;
  logic [CIW-1:0]  col;
  logic [N-1:0]    snap, prev, frame;
  logic [SW-1:0]   stable_cnt, cnt_nxt;
  state_t          state, state_nxt;
  logic            valid_nxt, held_nxt;
  logic [CW-1:0]   code_nxt;
  onehot_t         oh;
  logic            last_dwell, frame_end, stable, nz;
  key_sync #(.W(ROWS)) u_sync (.clk(clk), .reset(reset), .d(key_row), .q(rows_s));
  assign last_dwell = dwell == DW'(SCAN_DIV - 1);
  assign frame_end  = last_dwell && col == CIW'(COLS - 1);
  // the last column's rows arrive straight from the synchronizer on the frame-end cycle
  assign frame   = {rows_s, snap[N-ROWS-1:0]};
  assign nz      = |frame;
  assign cnt_nxt = (frame != prev) ? SW'(1) : (stable_cnt == SW'(DEBOUNCE)) ? stable_cnt : stable_cnt + 1'b1;
  assign stable  = cnt_nxt == SW'(DEBOUNCE);
  assign oh      = onehot_index(64'(frame));
  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    held_nxt  = key_held;
    code_nxt  = key_code;
    if (frame_end)
      case (state)
        IDLE:         state_nxt = nz ? PRESS_WAIT : IDLE;
        PRESS_WAIT:
          if (!nz) state_nxt = IDLE;
          else if (stable && oh.single) begin
            state_nxt = HELD;
            valid_nxt = 1'b1;
            held_nxt  = 1'b1;
            code_nxt  = CW'(oh.idx);
          end
        HELD:         state_nxt = nz ? HELD : RELEASE_WAIT;
        RELEASE_WAIT:
          if (nz) state_nxt = HELD;
          else if (stable) begin
            state_nxt = IDLE;
            held_nxt  = 1'b0;
          end
        default:      state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dwell      <= '0;
      col        <= '0;
      key_col    <= '0;
      snap       <= '0;
      prev       <= '0;
      stable_cnt <= '0;
      state      <= IDLE;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      dwell   <= last_dwell ? '0 : dwell + 1'b1;
      key_col <= {1'b1, {(COLS-1){1'b0}}} >> col;
      if (last_dwell) begin
        col                       <= frame_end ? '0 : col + 1'b1;
        snap[col*ROWS +: ROWS]    <= rows_s;
      end
      if (frame_end) begin
        prev       <= frame;
        stable_cnt <= cnt_nxt;
      end
      state     <= state_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
endmodule
